// File: rtl/svm_vec_streamer.sv
// Feature-vector packet source for the SVM classifier input_x stream port.
// Optional continuous replay is enabled by defining SVM_STREAM_LOOP_EN.
module svm_vec_streamer #(
  parameter  int DATA_W  = 32,
  parameter  int VEC_LEN = 16,
  parameter  int NUM_VEC = 8,
  parameter  int GAP_W   = 8,
  localparam int DEPTH   = NUM_VEC * VEC_LEN,
  localparam int CW      = $clog2(NUM_VEC + 1),
  localparam int PW      = $clog2(DEPTH + 1),
  localparam int AW      = $clog2(DEPTH),
  localparam int WW      = $clog2(VEC_LEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  output logic              wr_full,
  output logic [CW-1:0]     nvec,
  input  logic              start,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic              abort,
`ifdef SVM_STREAM_LOOP_EN
  input  logic              loop,
`endif
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_valid,
  output logic              out_eop,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [CW-1:0]     pkt_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [CW-1:0]     nvec_lat_q, nvec_lat_d;
  logic [CW-1:0]     pkt_cnt_q, pkt_cnt_d;
  logic [WW-1:0]     word_q, word_d;
  logic [GAP_W-1:0]  gap_lat_q, gap_lat_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              loop_w, loop_lat_q, loop_lat_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q, out_sop_q, out_eop_q;
  logic [AW-1:0]     rd_addr;
  logic              wr_full_w;
  logic [CW-1:0]     nvec_w;

`ifdef SVM_STREAM_LOOP_EN
  assign loop_w = loop;
`else
  assign loop_w = 1'b0;
`endif

  assign wr_full_w = (wr_ptr_q == PW'(DEPTH));
  // A trailing partial vector is never counted, so it is never sent.
  assign nvec_w    = CW'(32'(wr_ptr_q) / VEC_LEN);

  // NOTE: the buffer sits inside the async reset on purpose: reset must clear
  // stored vectors, not just rewind the write pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == IDLE) begin
      if (clr) begin
        wr_ptr_q <= '0;
      end else if (wr_en && !wr_full_w) begin
        mem_q[AW'(wr_ptr_q)] <= wr_data;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    pkt_cnt_d  = pkt_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    nvec_lat_d = nvec_lat_q;
    gap_lat_d  = gap_lat_q;
    loop_lat_d = loop_lat_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && nvec_w != '0) begin
          state_d    = SEND;
          word_d     = '0;
          pkt_cnt_d  = '0;
          nvec_lat_d = nvec_w;
          gap_lat_d  = gap_cycles;
          loop_lat_d = loop_w;
        end
      end
      SEND: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (out_ready) begin
          if (word_q != WW'(VEC_LEN - 1)) begin
            word_d = word_q + 1'b1;
          end else begin
            word_d = '0;
            if (pkt_cnt_q + 1'b1 < nvec_lat_q) begin
              pkt_cnt_d = pkt_cnt_q + 1'b1;
            end else if (loop_lat_q) begin
              pkt_cnt_d = '0;
            end else begin
              pkt_cnt_d = pkt_cnt_q + 1'b1;
              state_d   = IDLE;
              done_d    = 1'b1;
            end
            // The gap also separates the last packet of a pass from a looped restart.
            if (state_d == SEND && gap_lat_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_lat_q;
            end
          end
        end
      end
      GAP: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (gap_cnt_q == GAP_W'(1)) begin
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    rd_addr = AW'(32'(pkt_cnt_d) * VEC_LEN + 32'(word_d));
  end

  // Outputs are registered from next-state, so a stalled word keeps its index
  // and therefore its data, sop and eop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      word_q      <= '0;
      pkt_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      nvec_lat_q  <= '0;
      gap_lat_q   <= '0;
      loop_lat_q  <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      pkt_cnt_q   <= pkt_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      nvec_lat_q  <= nvec_lat_d;
      gap_lat_q   <= gap_lat_d;
      loop_lat_q  <= loop_lat_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      out_valid_q <= (state_d == SEND);
      out_sop_q   <= (state_d == SEND) && (word_d == '0);
      out_eop_q   <= (state_d == SEND) && (word_d == WW'(VEC_LEN - 1));
      if (state_d == SEND) out_data_q <= mem_q[rd_addr];
    end
  end

  assign wr_full   = wr_full_w;
  assign nvec      = nvec_w;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_valid = out_valid_q;
  assign out_eop   = out_eop_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_svm_vec_streamer.sv
// Self-checking bench for svm_vec_streamer: random stimulus against a queue-based
// model of the buffer and of the expected packet stream.
module tb_svm_vec_streamer;
  localparam int DW    = 32;
  localparam int VL    = 16;
  localparam int NV    = 2;
  localparam int GW    = 8;
  localparam int DEPTH = NV * VL;
  localparam int CW    = $clog2(NV + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, clr = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] wr_data = '0;
  logic [GW-1:0] gap_cycles = '0;
  logic          wr_full, out_sop, out_valid, out_eop, busy, done, aborted;
  logic [CW-1:0] nvec, pkt_cnt;
  logic [DW-1:0] out_data;
`ifdef SVM_STREAM_LOOP_EN
  logic          loop = 1'b0;
`endif

  svm_vec_streamer #(.DATA_W(DW), .VEC_LEN(VL), .NUM_VEC(NV), .GAP_W(GW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr(clr),
    .wr_full(wr_full), .nvec(nvec), .start(start), .gap_cycles(gap_cycles),
    .abort(abort),
`ifdef SVM_STREAM_LOOP_EN
    .loop(loop),
`endif
    .out_data(out_data), .out_sop(out_sop), .out_valid(out_valid),
    .out_eop(out_eop), .out_ready(out_ready), .busy(busy), .done(done),
    .aborted(aborted), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: buffer contents as seen by the host.
  logic [DW-1:0] mem_m[$];

  // Stream monitor: records every transfer and checks hold/qualification rules.
  int            cyc = 0;
  logic [DW-1:0] obs_d[$];
  bit            obs_s[$], obs_e[$];
  int            obs_c[$];
  int            done_cnt = 0, abort_cnt = 0, done_cyc = 0;
  logic          pv = 1'b0, pr = 1'b0, pa = 1'b0, ps = 1'b0, pe = 1'b0;
  logic [DW-1:0] pd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        obs_d.push_back(out_data);
        obs_s.push_back(out_sop);
        obs_e.push_back(out_eop);
        obs_c.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (aborted) abort_cnt++;
      if (!out_valid) check("sop_eop_unqualified", {out_sop, out_eop}, 2'b00);
      if (pv && !pr && !pa) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_word", {out_data, out_sop, out_eop}, {pd, ps, pe});
      end
    end
    pv = out_valid; pr = out_ready; pa = abort; pd = out_data; ps = out_sop; pe = out_eop;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (mem_m.size() < DEPTH) mem_m.push_back(d);
  endtask

  task automatic do_clear();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    mem_m.delete();
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, "_nvec"}, nvec, mem_m.size() / VL);
    check({tag, "_full"}, wr_full, mem_m.size() == DEPTH);
    tick();
  endtask

  task automatic clear_obs();
    obs_d.delete(); obs_s.delete(); obs_e.delete(); obs_c.delete();
    done_cnt = 0;
    abort_cnt = 0;
  endtask

  // Expected stream: the loaded complete vectors in order, repeating for loops.
  task automatic compare_stream(input string tag, input int n);
    for (int i = 0; i < obs_d.size(); i++) begin
      check({tag, "_data"}, obs_d[i], mem_m[i % n]);
      check({tag, "_sop"}, obs_s[i], (i % VL) == 0);
      check({tag, "_eop"}, obs_e[i], (i % VL) == VL - 1);
    end
  endtask

  task automatic check_spacing(input string tag, input int gap);
    for (int i = 1; i < obs_c.size(); i++)
      check({tag, "_spacing"}, obs_c[i] - obs_c[i-1], (i % VL == 0) ? gap + 1 : 1);
  endtask

  task automatic start_pulse(input int gap);
    gap_cycles = GW'(gap);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("first_valid", out_valid, 1'b1);
  endtask

  // mode 0: ready always high; 1: random ready plus ignored writes while busy;
  // 2: ready held low for 5 cycles while buffer word 7 is presented.
  task automatic run_pass(input int gap, input int mode, input string tag);
    int n = (mem_m.size() / VL) * VL;
    int stall = 0;
    int t = 0;
    clear_obs();
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    start_pulse(gap);
    while (done_cnt == 0 && t < 2000) begin
      tick();
      t++;
      case (mode)
        1: begin
          out_ready = 1'($urandom_range(0, 1));
          wr_en     = busy & 1'($urandom_range(0, 1));
          clr       = busy & ($urandom_range(0, 7) == 0);
          wr_data   = $urandom;
        end
        2: begin
          if (out_valid && out_data == mem_m[7] && stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
    wr_en = 1'b0;
    clr = 1'b0;
    out_ready = 1'b1;
    check({tag, "_done_once"}, done_cnt, 1);
    @(negedge clk);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_pkt_cnt"}, pkt_cnt, n / VL);
    check({tag, "_words"}, obs_d.size(), n);
    compare_stream(tag, n);
    if (obs_c.size() > 0) check({tag, "_done_timing"}, done_cyc, obs_c[obs_c.size()-1] + 1);
    if (mode == 0) check_spacing(tag, gap);
    if (mode == 2) check({tag, "_stall_cycles"}, stall, 5);
    tick();
  endtask

  initial begin
    int hit;
    int t;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", {out_valid, out_sop, out_eop, busy, done, aborted, wr_full}, 7'b0);
    check("rst_data", out_data, 0);
    check("rst_counts", {pkt_cnt, nvec}, 0);
    tick();
    rst = 1'b0;
    tick();

    // Two full vectors 0..31, extra write refused when full
    for (int i = 0; i < DEPTH; i++) write_word(DW'(i));
    check_status("load_full");
    write_word(32'hdead_beef);
    check_status("write_when_full");

    run_pass(0, 0, "b2b");
    run_pass(3, 0, "gap3");
    run_pass(0, 2, "stall");
    run_pass($urandom_range(0, 4), 1, "rand");

    // Abort at word 9 of packet 0
    clear_obs();
    out_ready = 1'b1;
    start_pulse(0);
    hit = 0;
    t = 0;
    while (!hit && t < 200) begin
      tick();
      t++;
      if (out_valid && out_data == mem_m[9]) hit = 1;
    end
    check("abort_reached_word9", hit, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_valid_low", out_valid, 1'b0);
    check("abort_pulse", aborted, 1'b1);
    check("abort_busy_low", busy, 1'b0);
    repeat (5) tick();
    check("abort_no_done", done_cnt, 0);
    check("abort_pulse_once", abort_cnt, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle_ignored", {aborted, busy}, 2'b00);
    tick();
    run_pass(0, 0, "replay");

    // clr beats a simultaneous write; start with nvec=0 is ignored
    clr = 1'b1; wr_en = 1'b1; wr_data = 32'h5;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    mem_m.delete();
    check_status("clr_wins");
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("start_empty_busy", {busy, out_valid}, 2'b00);
    end
    tick();

    // Partial load: 20 words gives one vector; busy-time writes/clears ignored
    for (int i = 0; i < 20; i++) write_word($urandom);
    check_status("partial");
    run_pass($urandom_range(0, 3), 1, "partial");
    check_status("partial_after");

    do_clear();
    for (int i = 0; i < DEPTH; i++) write_word($urandom);
    check_status("reload");
    run_pass($urandom_range(0, 5), 1, "rand2");

`ifdef SVM_STREAM_LOOP_EN
    // Continuous replay for at least three passes, then abort
    n = DEPTH;
    clear_obs();
    loop = 1'b1;
    out_ready = 1'b1;
    start_pulse(2);
    t = 0;
    while (obs_d.size() < 3 * n + VL && t < 2000) begin
      tick();
      t++;
    end
    check("loop_three_passes", obs_d.size() >= 3 * n + VL, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    loop = 1'b0;
    @(negedge clk);
    check("loop_abort_busy", busy, 1'b0);
    check("loop_no_done", done_cnt, 0);
    compare_stream("loop", n);
    check_spacing("loop", 2);
    tick();
    run_pass(0, 0, "loop_off");
`endif

    // Asynchronous reset in the middle of a packet
    out_ready = 1'b1;
    start_pulse(0);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("midrst_out", {out_valid, out_sop, out_eop, busy, done, aborted, wr_full}, 7'b0);
    check("midrst_data", out_data, 0);
    check("midrst_counts", {pkt_cnt, nvec}, 0);
    mem_m.delete();
    tick();
    rst = 1'b0;
    tick();
    check_status("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
